sccb_master_wr: RTL

SCCB (I2C-compatible) 3-phase write master for the OV7670 camera. It sits directly downstream of the camera initialisation sequencer. The sequencer issues one register-address/register-data pair per request. This block serialises the slave-ID, address and data bytes onto SIO_C/SIO_D and reports completion, so the sequencer can step through its register table.

---
 rtl/sccb_pkg.sv | 20 ++
 rtl/sccb_master_wr_if.sv | 13 +
 rtl/sccb_tick_gen.sv | 36 +++
 rtl/sccb_master_wr.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB 3-phase write master.
// Frame layout: ID, addr, data bytes MSB first, each followed by a don't-care slot.
package sccb_pkg;

   typedef enum logic [1:0] {IDLE, START, XFER, STOP} state_t;

   localparam int FRAME_BITS = 27;
   localparam logic [4:0] DC_SLOT0 = 5'd8;
   localparam logic [4:0] DC_SLOT1 = 5'd17;
   localparam logic [4:0] DC_SLOT2 = 5'd26;

   function automatic int calc_div(input int clk_freq, input int sccb_freq);
      return clk_freq / (sccb_freq * 4);
   endfunction

   function automatic logic is_slot(input logic [4:0] bit_idx);
      return (bit_idx == DC_SLOT0) || (bit_idx == DC_SLOT1) || (bit_idx == DC_SLOT2);
   endfunction

endpackage

// File: rtl/sccb_master_wr_if.sv
// Request/status bundle between the init sequencer (master) and the SCCB writer (slave).
// One request per transaction; busy/done/ack_err report progress and result.
interface sccb_master_wr_if;
   logic       req;
   logic [7:0] reg_addr;
   logic [7:0] reg_data;
   logic       busy;
   logic       done;
   logic       ack_err;

   modport master (output req, reg_addr, reg_data, input busy, done, ack_err);
   modport slave  (input req, reg_addr, reg_data, output busy, done, ack_err);
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit divider: tick every DIV cycles and a 2-bit quarter index; held at 0 while en=0.
// Latency: first tick DIV cycles after en rises; no backpressure.
module sccb_tick_gen #(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       tick,
   output logic [1:0] quarter
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(DIV - 1));
   assign tick = en && wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         quarter <= 2'd0;
      end else if (!en) begin
         cnt     <= '0;
         quarter <= 2'd0;
      end else if (wrap) begin
         cnt     <= '0;
         quarter <= quarter + 2'd1;
      end else begin
         cnt     <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sccb_master_wr.sv
// SCCB 3-phase write master: START, 27-bit frame (ID/addr/data + don't-care slots), STOP.
// Latency: done pulses 116*DIV+1 cycles after accept; req while busy is dropped, not queued.
module sccb_master_wr
   import sccb_pkg::*;
#(
   parameter int         CLK_FREQ  = 50_000_000,
   parameter int         SCCB_FREQ = 100_000,
   parameter logic [7:0] SLAVE_ID  = 8'h42
) (
   input  logic             clk,
   input  logic             rst_n,
   sccb_master_wr_if.slave  host,
   output logic             sio_c,
   inout  wire              sio_d
);

   localparam int DIV = calc_div(CLK_FREQ, SCCB_FREQ);

   if (DIV < 1) begin : g_bad_div
      $error("sccb_master_wr: CLK_FREQ/(SCCB_FREQ*4) must be at least 1");
   end

   state_t                state, state_nxt;
   logic [4:0]            bit_cnt, bit_cnt_nxt;
   logic [FRAME_BITS-1:0] shift, shift_nxt;
   logic [1:0]            quarter, quarter_nxt;
   logic                  tick;
   logic                  c_nxt, oe_nxt, d_nxt, oe, d_out;
   logic                  done_nxt, ack_nxt, done_q, ack_q;

   sccb_tick_gen #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state != IDLE),
      .tick    (tick),
      .quarter (quarter)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= 5'd0;
         shift   <= '0;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
         sio_c   <= 1'b1;
         oe      <= 1'b0;
         d_out   <= 1'b1;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift   <= shift_nxt;
         done_q  <= done_nxt;
         ack_q   <= ack_nxt;
         sio_c   <= c_nxt;
         oe      <= oe_nxt;
         d_out   <= d_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      done_nxt    = 1'b0;
      ack_nxt     = ack_q;
      quarter_nxt = tick ? quarter + 2'd1 : quarter;

      case (state)
         IDLE: begin
            if (host.req) begin
               state_nxt   = START;
               bit_cnt_nxt = 5'd0;
               shift_nxt   = {SLAVE_ID, 1'b0, host.reg_addr, 1'b0, host.reg_data, 1'b0};
               ack_nxt     = 1'b0;
               quarter_nxt = 2'd0;
            end
         end
         START: begin
            if (tick && quarter == 2'd3) state_nxt = XFER;
         end
         XFER: begin
            // Line is sampled as q3 begins, i.e. on the edge that closes q2.
            if (tick && quarter == 2'd2 && is_slot(bit_cnt) && sio_d) ack_nxt = 1'b1;
            if (tick && quarter == 2'd3) begin
               if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                  state_nxt = STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 5'd1;
                  shift_nxt   = {shift[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         STOP: begin
            if (tick && quarter == 2'd3) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Pins are decoded from the next-cycle view so the registered outputs line up with the quarters.
      c_nxt  = 1'b1;
      oe_nxt = 1'b0;
      d_nxt  = 1'b1;
      case (state_nxt)
         START: begin
            oe_nxt = 1'b1;
            d_nxt  = ~quarter_nxt[1];
         end
         XFER: begin
            c_nxt  = quarter_nxt[1];
            oe_nxt = !is_slot(bit_cnt_nxt);
            d_nxt  = shift_nxt[FRAME_BITS-1];
         end
         STOP: begin
            c_nxt  = quarter_nxt[1];
            oe_nxt = 1'b1;
            d_nxt  = (quarter_nxt == 2'd3);
         end
         default: ;
      endcase
   end

   assign sio_d        = oe ? d_out : 1'bz;
   assign host.busy    = (state != IDLE);
   assign host.done    = done_q;
   assign host.ack_err = ack_q;

endmodule
